tx_qpsk_symbol_mapper: RTL



---
 rtl/tx_pkg.sv | 14 +
 rtl/tx_qpsk_symbol_mapper_qpsk_map.sv | 18 +
 rtl/tx_qpsk_symbol_mapper.sv | 91 +++++++++
 3 files changed

// File: rtl/tx_pkg.sv
// Shared transmitter constants and the symbol-mapper state type.
// Used by the transmitter, the QPSK mapper and the IFFT stage.
package tx_pkg;

    localparam int N_CBPS   = 180;  // coded bits per block
    localparam int QPSK_AMP = 91;   // about 128/sqrt(2)
    localparam int SYM_W    = 8;    // signed I/Q sample width

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } tx_state_t;

endpackage

// File: rtl/tx_qpsk_symbol_mapper_qpsk_map.sv
// Combinational Gray-coded QPSK point: bit 0 selects I polarity, bit 1 selects Q polarity.
// Kept separate so a later mapper selector can add 16-QAM/64-QAM siblings.
module qpsk_map #(
    parameter int W   = 8,
    parameter int AMP = 91
) (
    input  logic [1:0]          bits,
    output logic signed [W-1:0] i_val,
    output logic signed [W-1:0] q_val
);

    localparam logic signed [W-1:0] POS = W'(AMP);
    localparam logic signed [W-1:0] NEG = W'(-AMP);

    assign i_val = bits[0] ? POS : NEG;
    assign q_val = bits[1] ? POS : NEG;

endmodule

// File: rtl/tx_qpsk_symbol_mapper.sv
// Captures a coded block on its strobe and streams it out as QPSK symbols,
// two bits per symbol (bit 0 first), under valid/ready backpressure.
module tx_qpsk_symbol_mapper
    import tx_pkg::*;
#(
    parameter int N_BITS = N_CBPS,
    parameter int W      = SYM_W,
    parameter int AMP    = QPSK_AMP
) (
    input  logic                Clk,
    input  logic                reset,
    input  logic [N_BITS-1:0]   blk_in,
    input  logic                blk_valid,
    output logic                blk_accept,
    output logic signed [W-1:0] sym_i,
    output logic signed [W-1:0] sym_q,
    output logic                sym_valid,
    input  logic                sym_ready,
    output logic [6:0]          sym_index,
    output logic                sym_last,
    output logic                overflow
);

    localparam logic [6:0] LAST_IDX = 7'(N_BITS / 2 - 1);

    tx_state_t         state;
    logic [N_BITS-1:0] shift_reg;
    logic [6:0]        idx;
    logic              transfer;
    logic signed [W-1:0] map_i;
    logic signed [W-1:0] map_q;

    qpsk_map #(
        .W   (W),
        .AMP (AMP)
    ) u_map (
        .bits  (shift_reg[1:0]),
        .i_val (map_i),
        .q_val (map_q)
    );

    assign sym_valid  = (state == SEND);
    assign sym_last   = sym_valid && (idx == LAST_IDX);
    assign sym_index  = idx;
    assign transfer   = sym_valid && sym_ready;
    assign blk_accept = (state == IDLE) || (transfer && sym_last);

    // Outputs read as zero whenever no symbol is presented.
    assign sym_i = sym_valid ? map_i : '0;
    assign sym_q = sym_valid ? map_q : '0;

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clk) begin
        if (reset) begin
            state     <= IDLE;
            shift_reg <= '0;
            idx       <= '0;
            overflow  <= 1'b0;
        end else begin
            if (blk_valid && !blk_accept)
                overflow <= 1'b1;

            case (state)
                IDLE: begin
                    if (blk_valid) begin
                        shift_reg <= blk_in;
                        idx       <= '0;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    if (transfer) begin
                        if (sym_last) begin
                            if (blk_valid) begin
                                shift_reg <= blk_in;
                                idx       <= '0;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            shift_reg <= shift_reg >> 2;
                            idx       <= idx + 7'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
